// File: rtl/string_char_scan_if.sv
// Queue-side and control/result signal bundle for string_char_scan.
// The master side is the Avalon wrapper together with the word queue; the slave side is the scanner.
interface string_char_scan_if #(
  parameter int unsigned CNT_W = 7
);
  logic             go;
  logic [7:0]       target;
  logic             fifo_empty;
  logic [31:0]      fifo_rdata;
  logic             fifo_rd;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] str_len;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] first_index;
  logic             found;
  logic             overflow;

  modport master (
    output go, target, fifo_empty, fifo_rdata,
    input  fifo_rd, busy, done, str_len, match_count, first_index, found, overflow
  );

  modport slave (
    input  go, target, fifo_empty, fifo_rdata,
    output fifo_rd, busy, done, str_len, match_count, first_index, found, overflow
  );
endinterface

// File: rtl/string_char_scan.sv
// Pops packed 4-char words and scans them for a NUL-terminated string.
// Define STRING_SCAN_CASE_FOLD_EN to make target matching case-insensitive for A-Z.
module string_char_scan #(
  parameter int unsigned MAX_WORDS = 16,
  parameter int unsigned CNT_W     = 7
) (
  input logic               clk,
  input logic               reset,
  string_char_scan_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SCAN  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [7:0]       tgt;
  logic [CNT_W-1:0] word_num;
  logic [CNT_W-1:0] char_base;
  logic [CNT_W-1:0] len_n, cnt_n, idx_n;
  logic             found_n, nul_n;
  logic [7:0]       b;

  function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef STRING_SCAN_CASE_FOLD_EN
    fold = (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
`else
    fold = c;
`endif
  endfunction

  assign bus.fifo_rd = (state == FETCH) && !bus.fifo_empty;
  assign char_base   = word_num << 2;

  // NUL bytes never reach the compare, so a target of 8'h00 cannot match.
  always_comb begin
    len_n   = bus.str_len;
    cnt_n   = bus.match_count;
    idx_n   = bus.first_index;
    found_n = bus.found;
    nul_n   = 1'b0;
    b       = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      b = bus.fifo_rdata[31 - 8*i -: 8];
      if (!nul_n) begin
        if (b == 8'h00) begin
          nul_n = 1'b1;
        end else begin
          len_n = len_n + CNT_W'(1);
          if (fold(b) == tgt) begin
            cnt_n = cnt_n + CNT_W'(1);
            if (!found_n) begin
              found_n = 1'b1;
              idx_n   = char_base + CNT_W'(i);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      tgt             <= '0;
      word_num        <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.str_len     <= '0;
      bus.match_count <= '0;
      bus.first_index <= '0;
      bus.found       <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.go) begin
            tgt             <= fold(bus.target);
            word_num        <= '0;
            bus.str_len     <= '0;
            bus.match_count <= '0;
            bus.first_index <= '0;
            bus.found       <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.done        <= 1'b0;
            bus.busy        <= 1'b1;
            state           <= FETCH;
          end
        end
        FETCH: begin
          if (!bus.fifo_empty) state <= SCAN;
        end
        SCAN: begin
          bus.str_len     <= len_n;
          bus.match_count <= cnt_n;
          bus.first_index <= idx_n;
          bus.found       <= found_n;
          if (nul_n || word_num == CNT_W'(MAX_WORDS - 1)) begin
            bus.overflow <= !nul_n;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            state        <= DONE;
          end else begin
            word_num <= word_num + CNT_W'(1);
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_string_char_scan.sv
// Directed bench for string_char_scan: queue model, expected-result scoreboard, immediate assertions.
module tb_string_char_scan;
  localparam int unsigned CNT_W = 7;

  typedef struct {
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] idx;
    logic             fnd;
    logic             ovf;
    int               pops;
    int               cycles;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  string_char_scan_if #(.CNT_W(CNT_W)) bus ();

  string_char_scan #(.MAX_WORDS(16), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] q[$];
  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          pops  = 0;
  logic        hold_empty = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_empty();
    bus.fifo_empty = hold_empty || (q.size() == 0);
  endtask

  // One clock: sample the pop request mid-cycle, then model the queue's registered read.
  task automatic tick();
    logic rd;
    @(negedge clk);
    rd = bus.fifo_rd;
    if (rd) chk("rd_while_empty", {31'd0, bus.fifo_empty}, 32'd0);
    @(posedge clk);
    #1;
    if (rd) begin
      pops++;
      if (q.size() > 0) bus.fifo_rdata = q.pop_front();
    end
    update_empty();
  endtask

  task automatic run_scan(input logic [7:0] tgt, input int stall, input logic go2);
    exp_t e;
    int   n;
    pops = 0;
    bus.go = 1'b1;
    bus.target = tgt;
    hold_empty = (stall > 0);
    update_empty();
    tick();
    bus.go = 1'b0;
    n = 1;
    for (int s = 0; s < stall; s++) begin
      if (go2 && s == 1) begin
        bus.go = 1'b1;
        bus.target = 8'h42;
      end else begin
        bus.go = 1'b0;
      end
      tick();
      n++;
    end
    bus.go = 1'b0;
    hold_empty = 1'b0;
    update_empty();
    while (!bus.done && n < 200) begin
      tick();
      n++;
    end
    chk("done_reached", {31'd0, bus.done}, 32'd1);
    e = sb.pop_front();
    chk("str_len",     {25'd0, bus.str_len},     {25'd0, e.len});
    chk("match_count", {25'd0, bus.match_count}, {25'd0, e.cnt});
    chk("first_index", {25'd0, bus.first_index}, {25'd0, e.idx});
    chk("found",       {31'd0, bus.found},       {31'd0, e.fnd});
    chk("overflow",    {31'd0, bus.overflow},    {31'd0, e.ovf});
    chk("busy_clear",  {31'd0, bus.busy},        32'd0);
    chk("pops",        pops,                     e.pops);
    if (e.cycles > 0) chk("latency", n, e.cycles);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  {31'd0, bus.busy},  32'd0);
    chk({tag, "_done"},  {31'd0, bus.done},  32'd0);
    chk({tag, "_len"},   {25'd0, bus.str_len}, 32'd0);
    chk({tag, "_cnt"},   {25'd0, bus.match_count}, 32'd0);
    chk({tag, "_idx"},   {25'd0, bus.first_index}, 32'd0);
    chk({tag, "_found"}, {31'd0, bus.found}, 32'd0);
    chk({tag, "_ovf"},   {31'd0, bus.overflow}, 32'd0);
    chk({tag, "_rd"},    {31'd0, bus.fifo_rd}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.go = 1'b0;
    bus.target = 8'h00;
    bus.fifo_rdata = '0;
    update_empty();
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // "HELLO", target 'L'
    q.push_back(32'h48454C4C);
    q.push_back(32'h4F000000);
    sb.push_back('{len: 7'd5, cnt: 7'd2, idx: 7'd2, fnd: 1'b1, ovf: 1'b0, pops: 2, cycles: 5});
    run_scan(8'h4C, 0, 1'b0);
    chk("hello_q_left", q.size(), 0);

    // NUL in byte 0
    q.push_back(32'h00414141);
    sb.push_back('{len: 7'd0, cnt: 7'd0, idx: 7'd0, fnd: 1'b0, ovf: 1'b0, pops: 1, cycles: 3});
    run_scan(8'h41, 0, 1'b0);

    // 17 words with no NUL: only 16 popped
    for (int i = 0; i < 17; i++) q.push_back(32'h61616161);
    sb.push_back('{len: 7'd64, cnt: 7'd64, idx: 7'd0, fnd: 1'b1, ovf: 1'b1, pops: 16, cycles: 33});
    run_scan(8'h61, 0, 1'b0);
    chk("overflow_q_left", q.size(), 1);
    q.delete();
    update_empty();

    // Stall on empty queue, with a second go (different target) while busy
    q.push_back(32'h41420000);
    sb.push_back('{len: 7'd2, cnt: 7'd1, idx: 7'd0, fnd: 1'b1, ovf: 1'b0, pops: 1, cycles: 8});
    run_scan(8'h41, 5, 1'b1);

    // target 8'h00 never matches
    q.push_back(32'h41424344);
    q.push_back(32'h00000000);
    sb.push_back('{len: 7'd4, cnt: 7'd0, idx: 7'd0, fnd: 1'b0, ovf: 1'b0, pops: 2, cycles: 5});
    run_scan(8'h00, 0, 1'b0);

    // Case-fold sensitive word
    q.push_back(32'h41614100);
`ifdef STRING_SCAN_CASE_FOLD_EN
    sb.push_back('{len: 7'd3, cnt: 7'd3, idx: 7'd0, fnd: 1'b1, ovf: 1'b0, pops: 1, cycles: 3});
`else
    sb.push_back('{len: 7'd3, cnt: 7'd1, idx: 7'd1, fnd: 1'b1, ovf: 1'b0, pops: 1, cycles: 3});
`endif
    run_scan(8'h61, 0, 1'b0);

    // NUL in the last byte of the second word
    q.push_back(32'h78797A78);
    q.push_back(32'h62637800);
    sb.push_back('{len: 7'd7, cnt: 7'd3, idx: 7'd0, fnd: 1'b1, ovf: 1'b0, pops: 2, cycles: 5});
    run_scan(8'h78, 0, 1'b0);

    // Reset during SCAN of a 3-word string
    q.push_back(32'h61626364);
    q.push_back(32'h65666768);
    q.push_back(32'h696A0000);
    pops = 0;
    bus.go = 1'b1;
    bus.target = 8'h62;
    tick();
    bus.go = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_idle_outputs("midscan_reset");
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("midscan_rd_idle", {31'd0, bus.fifo_rd}, 32'd0);
    chk("midscan_pops", pops, 1);
    chk("midscan_q_left", q.size(), 2);
    chk("midscan_busy_after", {31'd0, bus.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
